// File: rtl/heap_array_pkg.sv
// heap_array_pkg: shared types for the heap array manager.
//   op_t    - request operation codes (3 bits; codes 6 and 7 are undefined
//             and are answered with an error)
//   state_t - control FSM states
package heap_array_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        ALLOC  = 3'd0,
        FREE   = 3'd1,
        WRITE  = 3'd2,
        READ   = 3'd3,
        SIZE   = 3'd4,
        RESIZE = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CLEAR,
        RESP
    } state_t;

endpackage

// File: rtl/heap_array_manager_if.sv
// heap_array_manager_if: request/response handshake bundle between the
// instruction sequencer (master) and the heap array manager (slave).
//   req_*  : valid/ready request carrying op, array id, index/size and data
//   rsp_*  : valid/ready response carrying result data and error flag
// Parameters: DW data width, AW array-id width, IW index/size width.
interface heap_array_manager_if #(
    parameter int DW = 12,
    parameter int AW = 2,
    parameter int IW = 3
);
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [AW-1:0] req_array;
    logic [IW-1:0] req_index;
    logic [DW-1:0] req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_error;

    modport master (
        output req_valid, req_op, req_array, req_index, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  req_valid, req_op, req_array, req_index, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_error
    );
endinterface

// File: rtl/heap_free_stack.sv
// heap_free_stack: LIFO of freed array ids, DEPTH entries (DEPTH >= 2).
//   clock, reset : clock, asynchronous active-high reset (empties the stack)
//   push, push_id: store an id on top (caller never pushes when full)
//   pop          : discard the top entry (caller never pops when empty)
//   top_id       : current top entry, 0 when empty
//   count        : number of stored ids
// push and pop are never asserted together by the owner.
module heap_free_stack #(
    parameter int DEPTH = 4,
    parameter int IDW   = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           push,
    input  logic           pop,
    input  logic [IDW-1:0] push_id,
    output logic [IDW-1:0] top_id,
    output logic [CW-1:0]  count
);
    logic [IDW-1:0] mem [DEPTH];
    logic [CW-1:0]  top_slot;

    assign top_slot = count - CW'(1);
    assign top_id   = (count == '0) ? '0 : mem[top_slot[PW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)     count <= '0;
        else if (push) count <= count + CW'(1);
        else if (pop)  count <= count - CW'(1);
    end

    // Entry storage needs no reset: only slots below count are ever read.
    always_ff @(posedge clock) begin
        if (push) mem[count[PW-1:0]] <= push_id;
    end
endmodule

// File: rtl/heap_array_manager.sv
// heap_array_manager: handshaked manager of NArrays fixed areas of NArea
// elements in a flat heap. One request in flight at a time.
//   clock, reset  : clock, asynchronous active-high reset
//   bus (slave)   : request op/array/index/data, response data/error
//   arrays_in_use : number of currently allocated arrays
// Optional build macro HEAP_CLEAR_ON_ALLOC_EN: a successful ALLOC zeroes
// the new area (one element per cycle) before responding. Without it the
// area keeps the previous owner's data.
module heap_array_manager
    import heap_array_pkg::*;
#(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 4,
    parameter int NArrays            = 4,
    localparam int AW = $clog2(NArrays),
    localparam int IW = $clog2(NArea + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    heap_array_manager_if.slave  bus,
    output logic [AW:0]          arrays_in_use
);
    localparam int DW  = MemoryElementWidth;
    localparam int HD  = NArrays * NArea;
    localparam int HAW = $clog2(HD);
    localparam int CW  = $clog2(NArrays + 1);
    localparam logic [AW:0]   NARR_C  = (AW+1)'(NArrays);
    localparam logic [IW-1:0] NAREA_C = IW'(NArea);

    state_t        state;
    logic [2:0]    op_r;
    logic [AW-1:0] array_r;
    logic [IW-1:0] index_r;
    logic [DW-1:0] data_r;

    logic          req_ready_r;
    logic          rsp_valid_r;
    logic          rsp_error_r;
    logic [DW-1:0] rsp_data_r;

    logic [AW:0]        fresh;
    logic [NArrays-1:0] allocated;
    logic [IW-1:0]      size_q [NArrays];
    logic [DW-1:0]      heap   [HD];

`ifdef HEAP_CLEAR_ON_ALLOC_EN
    logic [IW-1:0] clr_idx;
`endif

    logic          stk_push, stk_pop;
    logic [AW-1:0] stk_top;
    logic [CW-1:0] stk_count;

    logic          ex_err;
    logic [DW-1:0] ex_data;
    logic [AW-1:0] new_id;
    logic          new_fresh;
    logic          live, in_range, in_exec;
    logic [IW-1:0] idx_sel;
    logic [HAW-1:0] addr;
    logic          heap_we;
    logic [DW-1:0] heap_wdata;

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_error = rsp_error_r;
    assign bus.rsp_data  = rsp_data_r;

    heap_free_stack #(.DEPTH(NArrays), .IDW(AW)) u_free_stack (
        .clock   (clock),
        .reset   (reset),
        .push    (stk_push),
        .pop     (stk_pop),
        .push_id (array_r),
        .top_id  (stk_top),
        .count   (stk_count)
    );

    // During CLEAR, array_r holds the freshly allocated id.
`ifdef HEAP_CLEAR_ON_ALLOC_EN
    assign idx_sel = (state == CLEAR) ? clr_idx : index_r;
`else
    assign idx_sel = index_r;
`endif
    assign addr = HAW'(array_r) * HAW'(NArea) + HAW'(idx_sel);

    // Decode of the registered request; only acted on in EXEC.
    always_comb begin
        in_exec   = (state == EXEC);
        live      = allocated[array_r];
        in_range  = (index_r < NAREA_C);
        ex_err    = 1'b0;
        ex_data   = '0;
        new_id    = stk_top;
        new_fresh = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        case (op_r)
            ALLOC: begin
                // Recycled ids take priority over never-used ones.
                if (stk_count != '0) begin
                    stk_pop = in_exec;
                end else if (fresh < NARR_C) begin
                    new_id    = fresh[AW-1:0];
                    new_fresh = 1'b1;
                end else begin
                    ex_err = 1'b1;
                end
                if (!ex_err) ex_data = DW'(new_id);
            end
            FREE: begin
                ex_err   = !live;
                stk_push = live && in_exec;
            end
            WRITE: ex_err = !(live && in_range);
            READ: begin
                ex_err = !(live && in_range);
                if (!ex_err) ex_data = heap[addr];
            end
            SIZE: begin
                ex_err = !live;
                if (live) ex_data = DW'(size_q[array_r]);
            end
            RESIZE: ex_err = !live || (index_r > NAREA_C);
            default: ex_err = 1'b1;
        endcase
    end

    always_comb begin
        heap_we    = in_exec && (op_r == WRITE) && !ex_err;
        heap_wdata = data_r;
`ifdef HEAP_CLEAR_ON_ALLOC_EN
        if (state == CLEAR) begin
            heap_we    = 1'b1;
            heap_wdata = '0;
        end
`endif
    end

    // Heap contents are not reset.
    always_ff @(posedge clock) begin
        if (heap_we) heap[addr] <= heap_wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            req_ready_r   <= 1'b1;
            rsp_valid_r   <= 1'b0;
            rsp_error_r   <= 1'b0;
            rsp_data_r    <= '0;
            arrays_in_use <= '0;
            fresh         <= '0;
            allocated     <= '0;
            op_r          <= '0;
            array_r       <= '0;
            index_r       <= '0;
            data_r        <= '0;
            for (int i = 0; i < NArrays; i++) size_q[i] <= '0;
`ifdef HEAP_CLEAR_ON_ALLOC_EN
            clr_idx       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_r        <= bus.req_op;
                        array_r     <= bus.req_array;
                        index_r     <= bus.req_index;
                        data_r      <= bus.req_data;
                        req_ready_r <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_error_r <= ex_err;
                    rsp_data_r  <= ex_data;
                    rsp_valid_r <= 1'b1;
                    state       <= RESP;
                    if (!ex_err) begin
                        case (op_r)
                            ALLOC: begin
                                size_q[new_id]    <= '0;
                                allocated[new_id] <= 1'b1;
                                arrays_in_use     <= arrays_in_use + (AW+1)'(1);
                                if (new_fresh) fresh <= fresh + (AW+1)'(1);
`ifdef HEAP_CLEAR_ON_ALLOC_EN
                                array_r     <= new_id;
                                clr_idx     <= '0;
                                rsp_valid_r <= 1'b0;
                                state       <= CLEAR;
`endif
                            end
                            FREE: begin
                                allocated[array_r] <= 1'b0;
                                arrays_in_use      <= arrays_in_use - (AW+1)'(1);
                            end
                            WRITE: begin
                                // Writing past the current length extends it.
                                if (size_q[array_r] <= index_r)
                                    size_q[array_r] <= index_r + IW'(1);
                            end
                            RESIZE: size_q[array_r] <= index_r;
                            default: ;
                        endcase
                    end
                end
`ifdef HEAP_CLEAR_ON_ALLOC_EN
                CLEAR: begin
                    clr_idx <= clr_idx + IW'(1);
                    if (clr_idx == NAREA_C - IW'(1)) begin
                        rsp_valid_r <= 1'b1;
                        state       <= RESP;
                    end
                end
`endif
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_heap_array_manager.sv
// tb_heap_array_manager: directed scoreboard bench for heap_array_manager.
// Stimulus pushes hand-computed expected responses into a queue; a monitor
// pops and compares every accepted response. Works with or without
// HEAP_CLEAR_ON_ALLOC_EN.
module tb_heap_array_manager;
    import heap_array_pkg::*;

    localparam int DW = 12;
    localparam int NA = 4;
    localparam int NR = 4;

    typedef struct {
        logic [DW-1:0] d;
        bit            e;
        bit            cd;
        int            id;
    } exp_t;

    logic clock;
    logic reset;
    logic [2:0] arrays_in_use;

    heap_array_manager_if #(.DW(DW), .AW(2), .IW(3)) bus ();

    heap_array_manager #(.MemoryElementWidth(DW), .NArea(NA), .NArrays(NR)) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .arrays_in_use (arrays_in_use)
    );

    exp_t sb[$];
    int n_vec  = 0;
    int n_fail = 0;
    int issued = 0;
    int n_rsp  = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one comparison per response seen with valid && ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && bus.rsp_valid && bus.rsp_ready) begin
                n_vec++;
                n_rsp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp: data=%0d err=%0b with empty scoreboard",
                             bus.rsp_data, bus.rsp_error);
                end else begin
                    e = sb.pop_front();
                    if (bus.rsp_error !== e.e || (e.cd && bus.rsp_data !== e.d)) begin
                        n_fail++;
                        $display("FAIL rsp#%0d: got data=%0d err=%0b, expected data=%0d err=%0b",
                                 e.id, bus.rsp_data, bus.rsp_error, e.d, e.e);
                    end
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input int arr, input int idx, input int dat);
        bit ok;
        ok = 1'b0;
        @(negedge clock);
        bus.req_op    = op;
        bus.req_array = arr[1:0];
        bus.req_index = idx[2:0];
        bus.req_data  = dat[DW-1:0];
        bus.req_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready stayed 0, expected 1");
        end
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clock);
            #1;
            if (n_rsp >= issued) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL rsp_timeout: responses=%0d, expected %0d", n_rsp, issued);
        end
    endtask

    task automatic req(input logic [2:0] op, input int arr, input int idx, input int dat,
                       input int exp_d, input bit exp_e);
        exp_t e;
        e.d  = exp_d[DW-1:0];
        e.e  = exp_e;
        e.cd = !exp_e || (op == ALLOC);
        e.id = issued;
        sb.push_back(e);
        issued++;
        send(op, arr, idx, dat);
        wait_done();
    endtask

    task automatic wait_rsp_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (bus.rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL rsp_valid_timeout: rsp_valid stayed 0, expected 1");
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, bus.req_ready, 1);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_data"},  bus.rsp_data, 0);
        chk({tag, "_rsp_error"}, bus.rsp_error, 0);
        chk({tag, "_in_use"},    arrays_in_use, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_array = '0;
        bus.req_index = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        #3;
        chk_reset_vals("por");
        @(negedge clock);
        reset = 1'b0;

        // Program replay
        req(ALLOC, 0, 0, 0,  0, 0);
        req(WRITE, 0, 0, 11, 0, 0);
        req(WRITE, 0, 1, 22, 0, 0);
        req(ALLOC, 0, 0, 0,  1, 0);
        req(WRITE, 1, 1, 33, 0, 0);
        req(READ,  1, 1, 0, 33, 0);
        req(SIZE,  1, 0, 0,  2, 0);
        req(READ,  0, 0, 0, 11, 0);
        req(READ,  0, 1, 0, 22, 0);
        req(SIZE,  0, 0, 0,  2, 0);
        chk("replay_in_use", arrays_in_use, 2);

        // LIFO reuse
        req(ALLOC, 0, 0, 0, 2, 0);  chk("reuse_in_use_a", arrays_in_use, 3);
        req(FREE,  1, 0, 0, 0, 0);  chk("reuse_in_use_b", arrays_in_use, 2);
        req(FREE,  0, 0, 0, 0, 0);  chk("reuse_in_use_c", arrays_in_use, 1);
        req(ALLOC, 0, 0, 0, 0, 0);  chk("reuse_in_use_d", arrays_in_use, 2);
`ifdef HEAP_CLEAR_ON_ALLOC_EN
        req(READ,  0, 0, 0, 0, 0);
`else
        req(READ,  0, 0, 0, 11, 0);
`endif
        req(SIZE,  0, 0, 0, 0, 0);
        req(ALLOC, 0, 0, 0, 1, 0);  chk("reuse_in_use_e", arrays_in_use, 3);
        req(ALLOC, 0, 0, 0, 3, 0);  chk("reuse_in_use_f", arrays_in_use, 4);

        // Exhaustion
        req(ALLOC, 0, 0, 0, 0, 1);  chk("exhaust_in_use", arrays_in_use, 4);

        // Error cases and length tracking
        req(WRITE,  0, 2, 55, 0, 0);
        req(READ,   0, 4, 0,  0, 1);
        req(SIZE,   0, 0, 0,  3, 0);
        req(FREE,   2, 0, 0,  0, 0);  chk("free2_in_use", arrays_in_use, 3);
        req(FREE,   2, 0, 0,  0, 1);  chk("refree_in_use", arrays_in_use, 3);
        req(WRITE,  2, 0, 1,  0, 1);
        req(SIZE,   2, 0, 0,  0, 1);
        req(3'd7,   0, 0, 0,  0, 1);
        req(3'd6,   0, 0, 0,  0, 1);  chk("badop_in_use", arrays_in_use, 3);
        req(RESIZE, 0, 5, 0,  0, 1);
        req(SIZE,   0, 0, 0,  3, 0);
        req(RESIZE, 0, 4, 0,  0, 0);
        req(SIZE,   0, 0, 0,  4, 0);
        req(RESIZE, 0, 1, 0,  0, 0);
        req(READ,   0, 2, 0, 55, 0);
        req(SIZE,   0, 0, 0,  1, 0);
        req(WRITE,  0, 3, 4095, 0, 0);
        req(SIZE,   0, 0, 0,  4, 0);
        req(READ,   0, 3, 0, 4095, 0);
        req(WRITE,  0, 0, 9,  0, 0);
        req(SIZE,   0, 0, 0,  4, 0);

        // Backpressure with latency check
        @(posedge clock);
        #1 bus.rsp_ready = 1'b0;
        begin
            exp_t e;
            e.d = 12'd55; e.e = 1'b0; e.cd = 1'b1; e.id = issued;
            sb.push_back(e);
            issued++;
        end
        send(READ, 0, 2, 0);
        chk("lat_t1_rsp_valid", bus.rsp_valid, 0);
        @(posedge clock);
        #1 chk("lat_t2_rsp_valid", bus.rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_data",  bus.rsp_data, 55);
            chk("bp_rsp_error", bus.rsp_error, 0);
            chk("bp_req_ready", bus.req_ready, 0);
        end
        @(posedge clock);
        #1 bus.rsp_ready = 1'b1;
        wait_done();

        // Reset while a response is pending
        @(posedge clock);
        #1 bus.rsp_ready = 1'b0;
        send(SIZE, 0, 0, 0);
        wait_rsp_valid();
        #2 reset = 1'b1;
        #1 chk_reset_vals("rst_resp");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1 bus.rsp_ready = 1'b1;
        req(ALLOC, 0, 0, 0, 0, 0);
        chk("post_rst_in_use", arrays_in_use, 1);
        req(ALLOC, 0, 0, 0, 1, 0);

`ifdef HEAP_CLEAR_ON_ALLOC_EN
        // Reset in the middle of clearing a new area
        req(WRITE, 0, 0, 77, 0, 0);
        send(ALLOC, 0, 0, 0);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 chk_reset_vals("rst_clear");
        @(negedge clock);
        reset = 1'b0;
        req(ALLOC, 0, 0, 0, 0, 0);
        req(READ,  0, 0, 0, 0, 0);
        req(ALLOC, 0, 0, 0, 1, 0);
        req(READ,  1, 1, 0, 0, 0);
`endif

        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
